core_irq_ctrl: RTL and testbench

CORE_IRQ_CTRL -- requirements
Module: core_irq_ctrl

---
 rtl/croc_pkg.sv | 26 ++
 rtl/core_irq_sync.sv | 30 +++
 rtl/core_irq_ctrl.sv | 151 +++++++++++++++
 tb/tb_core_irq_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/croc_pkg.sv
// Shared definitions for the fast-interrupt controller: register offsets and channel modes.
// Latency: n/a (types, constants and a constant-evaluable helper only).
// Backpressure: n/a.
package croc_pkg;

   localparam logic [3:0] IrqPendingOffset = 4'h0;
   localparam logic [3:0] IrqEnableOffset  = 4'h4;
   localparam logic [3:0] IrqModeOffset    = 4'h8;
   localparam logic [3:0] IrqStatusOffset  = 4'hC;

   typedef enum logic {
      IrqLevel = 1'b0,
      IrqEdge  = 1'b1
   } irq_mode_e;

   // Mask of the implemented channels; unimplemented bits read 0 and ignore writes.
   function automatic logic [31:0] irq_chan_mask(input int n);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < n) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/core_irq_sync.sv
// Multi-bit flop-chain synchroniser bringing asynchronous lines into clk_i.
// Latency: Depth cycles from d_i to q_o.
// Backpressure: none, free-running every cycle.
module core_irq_sync #(
   parameter int Width = 1,
   parameter int Depth = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Depth-1:0][Width-1:0] r_chain;

   // Shift the raw lines through the chain; stage 0 is the metastability catcher.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_chain <= '0;
      end else begin
         r_chain[0] <= d_i;
         for (int i = 1; i < Depth; i++) begin
            r_chain[i] <= r_chain[i-1];
         end
      end
   end

   assign q_o = r_chain[Depth-1];

endmodule

// File: rtl/core_irq_ctrl.sv
// Fast-interrupt controller: sync, level/edge pending capture, enable masking, register port.
// Latency: irqs_i to irq_fast_o is SyncStages+2 cycles; register response 1 cycle after request.
// Backpressure: none, every request is granted combinationally and accepted each cycle.
module core_irq_ctrl
   import croc_pkg::*;
#(
   parameter int NumIrqs    = 32,
   parameter int SyncStages = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NumIrqs-1:0] irqs_i,
   input  logic               reg_req_i,
   input  logic               reg_we_i,
   input  logic [3:0]         reg_addr_i,
   input  logic [3:0]         reg_be_i,
   input  logic [31:0]        reg_wdata_i,
   output logic               reg_gnt_o,
   output logic               reg_rvalid_o,
   output logic [31:0]        reg_rdata_o,
   output logic [31:0]        irq_fast_o,
   output logic               wake_o
);

   localparam logic [31:0] ChanMask = irq_chan_mask(NumIrqs);

   logic [NumIrqs-1:0] w_sync_raw;
   logic [31:0]        w_sync;
   logic [31:0]        w_be_mask;
   logic [31:0]        w_wmask;
   logic               w_wr;
   logic               w_rd;
   logic               w_sel_pending;
   logic               w_sel_enable;
   logic               w_sel_mode;
   logic [31:0]        w_enable_nxt;
   logic [31:0]        w_mode_nxt;
   logic [31:0]        w_mode_rise;
   logic [31:0]        w_w1c;
   logic [31:0]        w_edge;
   logic [31:0]        w_pending_nxt;
   logic [31:0]        w_rdata_mux;
   logic               w_unused_addr;

   logic [31:0] r_prev;
   logic [31:0] r_pending;
   logic [31:0] r_enable;
   logic [31:0] r_mode;
   logic [31:0] r_irq_fast;
   logic [31:0] r_rdata;
   logic        r_rvalid;

   core_irq_sync #(
      .Width (NumIrqs),
      .Depth (SyncStages)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (irqs_i),
      .q_o    (w_sync_raw)
   );

   // Widen the synchronised lines to the 32-bit register view; missing channels read 0.
   always_comb begin
      w_sync                = '0;
      w_sync[NumIrqs-1:0]   = w_sync_raw;
   end

   // Only word offsets are decoded; the byte-offset bits are deliberately ignored.
   assign w_unused_addr = ^reg_addr_i[1:0];

   assign w_wr = reg_req_i & reg_we_i;
   assign w_rd = reg_req_i & ~reg_we_i;

   assign w_sel_pending = w_wr & (reg_addr_i[3:2] == IrqPendingOffset[3:2]);
   assign w_sel_enable  = w_wr & (reg_addr_i[3:2] == IrqEnableOffset[3:2]);
   assign w_sel_mode    = w_wr & (reg_addr_i[3:2] == IrqModeOffset[3:2]);

   assign w_be_mask = {{8{reg_be_i[3]}}, {8{reg_be_i[2]}}, {8{reg_be_i[1]}}, {8{reg_be_i[0]}}};
   assign w_wmask   = w_be_mask & ChanMask;

   assign w_enable_nxt = w_sel_enable ? ((r_enable & ~w_wmask) | (reg_wdata_i & w_wmask)) : r_enable;
   assign w_mode_nxt   = w_sel_mode   ? ((r_mode   & ~w_wmask) | (reg_wdata_i & w_wmask)) : r_mode;
   assign w_mode_rise  = w_mode_nxt & ~r_mode;
   assign w_w1c        = w_sel_pending ? (reg_wdata_i & w_wmask) : '0;
   assign w_edge       = w_sync & ~r_prev;

   // Per-channel pending update: a level->edge switch flushes the stale level,
   // edge channels hold until W1C with a fresh edge winning, level channels follow sync.
   always_comb begin
      w_pending_nxt = '0;
      for (int i = 0; i < 32; i++) begin
         if (w_mode_rise[i]) begin
            w_pending_nxt[i] = 1'b0;
         end else if (irq_mode_e'(r_mode[i]) == IrqEdge) begin
            w_pending_nxt[i] = (r_pending[i] & ~w_w1c[i]) | w_edge[i];
         end else begin
            w_pending_nxt[i] = w_sync[i];
         end
      end
      w_pending_nxt = w_pending_nxt & ChanMask;
   end

   // Read data selection; reads have no side effects.
   always_comb begin
      w_rdata_mux = '0;
      case (reg_addr_i[3:2])
         IrqPendingOffset[3:2]: w_rdata_mux = r_pending;
         IrqEnableOffset[3:2]:  w_rdata_mux = r_enable;
         IrqModeOffset[3:2]:    w_rdata_mux = r_mode;
         IrqStatusOffset[3:2]:  w_rdata_mux = w_sync;
         default:               w_rdata_mux = '0;
      endcase
   end

   // Interrupt state: previous-sync tracks sync every cycle, so after a mode switch the
   // edge detector already sees the current level and takes no spurious edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_prev     <= '0;
         r_pending  <= '0;
         r_enable   <= '0;
         r_mode     <= '0;
         r_irq_fast <= '0;
      end else begin
         r_prev     <= w_sync;
         r_pending  <= w_pending_nxt;
         r_enable   <= w_enable_nxt;
         r_mode     <= w_mode_nxt;
         r_irq_fast <= r_pending & r_enable;
      end
   end

   // Register response: one-cycle rvalid for every request, data only for reads.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= reg_req_i;
         r_rdata  <= w_rd ? w_rdata_mux : '0;
      end
   end

   assign reg_gnt_o    = reg_req_i;
   assign reg_rvalid_o = r_rvalid;
   assign reg_rdata_o  = r_rdata;
   assign irq_fast_o   = r_irq_fast;
   assign wake_o       = |r_irq_fast;

endmodule

// File: tb/tb_core_irq_ctrl.sv
// Directed bench for core_irq_ctrl: a 32-channel instance and an 8-channel instance.
// Latency: checks exact sync-to-output timing and one-cycle register responses.
// Backpressure: none expected; grant is checked against request.
module tb_core_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] irqs_a = '0;
   logic [7:0]  irqs_b = '0;
   logic        bus_req = 1'b0;
   logic        bus_we = 1'b0;
   logic [3:0]  bus_addr = '0;
   logic [3:0]  bus_be = '0;
   logic [31:0] bus_wdata = '0;
   logic        sel8 = 1'b0;

   logic        req_a, req_b;
   logic        gnt_a, gnt_b, rvalid_a, rvalid_b, wake_a, wake_b;
   logic [31:0] rdata_a, rdata_b, fast_a, fast_b;
   logic        gnt_m, rvalid_m;
   logic [31:0] rdata_m;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign req_a    = bus_req & ~sel8;
   assign req_b    = bus_req & sel8;
   assign gnt_m    = sel8 ? gnt_b : gnt_a;
   assign rvalid_m = sel8 ? rvalid_b : rvalid_a;
   assign rdata_m  = sel8 ? rdata_b : rdata_a;

   core_irq_ctrl #(.NumIrqs(32), .SyncStages(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .irqs_i(irqs_a),
      .reg_req_i(req_a), .reg_we_i(bus_we), .reg_addr_i(bus_addr), .reg_be_i(bus_be),
      .reg_wdata_i(bus_wdata), .reg_gnt_o(gnt_a), .reg_rvalid_o(rvalid_a),
      .reg_rdata_o(rdata_a), .irq_fast_o(fast_a), .wake_o(wake_a)
   );

   core_irq_ctrl #(.NumIrqs(8), .SyncStages(2)) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .irqs_i(irqs_b),
      .reg_req_i(req_b), .reg_we_i(bus_we), .reg_addr_i(bus_addr), .reg_be_i(bus_be),
      .reg_wdata_i(bus_wdata), .reg_gnt_o(gnt_b), .reg_rvalid_o(rvalid_b),
      .reg_rdata_o(rdata_b), .irq_fast_o(fast_b), .wake_o(wake_b)
   );

   // One write access: inputs change on the falling edge, response sampled one cycle later.
   task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
      @(negedge clk);
      bus_req = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = data; bus_be = be;
      @(negedge clk);
      n_cmp++; if (rvalid_m !== 1'b1) begin n_bad++; $display("FAIL wr_rvalid got %b want 1", rvalid_m); end
      n_cmp++; if (rdata_m !== 32'h0) begin n_bad++; $display("FAIL wr_rdata got %h want 0", rdata_m); end
      bus_req = 1'b0; bus_we = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
      @(negedge clk);
      bus_req = 1'b1; bus_we = 1'b0; bus_addr = addr; bus_be = 4'hF;
      #1;
      n_cmp++; if (gnt_m !== 1'b1) begin n_bad++; $display("FAIL rd_gnt got %b want 1", gnt_m); end
      @(negedge clk);
      n_cmp++; if (rvalid_m !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid got %b want 1", rvalid_m); end
      data = rdata_m;
      bus_req = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (fast_a !== 32'h0 || wake_a !== 1'b0) begin n_bad++; $display("FAIL rst_fast got %h/%b want 0/0", fast_a, wake_a); end
      n_cmp++; if (rvalid_a !== 1'b0 || rdata_a !== 32'h0) begin n_bad++; $display("FAIL rst_resp got %b/%h want 0/0", rvalid_a, rdata_a); end
      n_cmp++; if (fast_b !== 32'h0 || rvalid_b !== 1'b0) begin n_bad++; $display("FAIL rst_dut8 got %h/%b want 0/0", fast_b, rvalid_b); end
      rst_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         bus_read(4'(a * 4), d);
         n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_reg%0d got %h want 0", a, d); end
      end
   endtask

   task automatic test_level();
      bus_write(4'h4, 32'h1, 4'hF);
      irqs_a[0] = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (fast_a !== 32'h0) begin n_bad++; $display("FAIL lvl_rise_early got %h want 0", fast_a); end
      @(negedge clk);
      n_cmp++; if (fast_a !== 32'h1 || wake_a !== 1'b1) begin n_bad++; $display("FAIL lvl_rise got %h/%b want 1/1", fast_a, wake_a); end
      irqs_a[0] = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (fast_a !== 32'h1) begin n_bad++; $display("FAIL lvl_fall_early got %h want 1", fast_a); end
      @(negedge clk);
      n_cmp++; if (fast_a !== 32'h0 || wake_a !== 1'b0) begin n_bad++; $display("FAIL lvl_fall got %h/%b want 0/0", fast_a, wake_a); end
   endtask

   task automatic test_edge_hold();
      logic [31:0] d;
      bus_write(4'h8, 32'h4, 4'hF);
      bus_write(4'h4, 32'h4, 4'hF);
      irqs_a[2] = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (fast_a !== 32'h0) begin n_bad++; $display("FAIL edge_early got %h want 0", fast_a); end
      irqs_a[2] = 1'b0;
      @(negedge clk);
      n_cmp++; if (fast_a !== 32'h4) begin n_bad++; $display("FAIL edge_lat got %h want 4", fast_a); end
      repeat (4) @(negedge clk);
      bus_read(4'h0, d);
      n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL edge_hold got %h want 4", d); end
      bus_write(4'h0, 32'h4, 4'hF);
      n_cmp++; if (fast_a !== 32'h4) begin n_bad++; $display("FAIL w1c_lag got %h want 4", fast_a); end
      @(negedge clk);
      n_cmp++; if (fast_a !== 32'h0) begin n_bad++; $display("FAIL w1c_drop got %h want 0", fast_a); end
      bus_read(4'h0, d);
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL w1c_pend got %h want 0", d); end
   endtask

   task automatic test_set_wins();
      logic [31:0] d;
      bus_write(4'h8, 32'h24, 4'hF);
      irqs_a[5] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus_req = 1'b1; bus_we = 1'b1; bus_addr = 4'h0; bus_wdata = 32'h20; bus_be = 4'hF;
      @(negedge clk);
      bus_req = 1'b0; bus_we = 1'b0;
      bus_read(4'h0, d);
      n_cmp++; if (d !== 32'h20) begin n_bad++; $display("FAIL set_wins got %h want 20", d); end
      bus_write(4'h0, 32'h20, 4'hF);
      repeat (3) @(negedge clk);
      bus_read(4'h0, d);
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL edge_noretrig got %h want 0", d); end
   endtask

   task automatic test_mode_switch();
      logic [31:0] d;
      irqs_a[3] = 1'b1;
      repeat (5) @(negedge clk);
      bus_read(4'h0, d);
      n_cmp++; if (d !== 32'h8) begin n_bad++; $display("FAIL lvl_pend got %h want 8", d); end
      bus_write(4'h0, 32'h8, 4'hF);
      bus_read(4'h0, d);
      n_cmp++; if (d !== 32'h8) begin n_bad++; $display("FAIL lvl_w1c_ign got %h want 8", d); end
      bus_write(4'h8, 32'h2C, 4'hF);
      bus_read(4'h0, d);
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mode_flush got %h want 0", d); end
      repeat (4) @(negedge clk);
      bus_read(4'h0, d);
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mode_nospur got %h want 0", d); end
      bus_read(4'hC, d);
      n_cmp++; if (d !== 32'h28) begin n_bad++; $display("FAIL status got %h want 28", d); end
   endtask

   task automatic test_enable_drop();
      logic [31:0] d;
      irqs_a[2] = 1'b1;
      repeat (3) @(negedge clk);
      irqs_a[2] = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (fast_a !== 32'h4) begin n_bad++; $display("FAIL en_pre got %h want 4", fast_a); end
      bus_write(4'h4, 32'h0, 4'hF);
      @(negedge clk);
      n_cmp++; if (fast_a !== 32'h0 || wake_a !== 1'b0) begin n_bad++; $display("FAIL en_drop got %h/%b want 0/0", fast_a, wake_a); end
      bus_read(4'h0, d);
      n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL en_retain got %h want 4", d); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus_req = 1'b1; bus_we = 1'b1; bus_addr = 4'h4; bus_wdata = 32'h11; bus_be = 4'hF;
      @(negedge clk);
      n_cmp++; if (rvalid_m !== 1'b1 || rdata_m !== 32'h0) begin n_bad++; $display("FAIL b2b_wr got %b/%h want 1/0", rvalid_m, rdata_m); end
      bus_we = 1'b0;
      @(negedge clk);
      n_cmp++; if (rvalid_m !== 1'b1 || rdata_m !== 32'h11) begin n_bad++; $display("FAIL b2b_rd_en got %b/%h want 1/11", rvalid_m, rdata_m); end
      bus_addr = 4'h8;
      @(negedge clk);
      n_cmp++; if (rvalid_m !== 1'b1 || rdata_m !== 32'h2C) begin n_bad++; $display("FAIL b2b_rd_mode got %b/%h want 1/2c", rvalid_m, rdata_m); end
      bus_req = 1'b0;
      #1;
      n_cmp++; if (gnt_m !== 1'b0) begin n_bad++; $display("FAIL b2b_gnt_idle got %b want 0", gnt_m); end
      @(negedge clk);
      n_cmp++; if (rvalid_m !== 1'b0) begin n_bad++; $display("FAIL b2b_rvalid_idle got %b want 0", rvalid_m); end
   endtask

   task automatic test_narrow();
      logic [31:0] d;
      sel8 = 1'b1;
      irqs_b = 8'h81;
      bus_write(4'h4, 32'hFFFF_FFFF, 4'hF);
      bus_read(4'h4, d);
      n_cmp++; if (d !== 32'hFF) begin n_bad++; $display("FAIL n8_en_all got %h want ff", d); end
      bus_write(4'h4, 32'h0000_AA00, 4'h2);
      bus_read(4'h4, d);
      n_cmp++; if (d !== 32'hFF) begin n_bad++; $display("FAIL n8_be_hi got %h want ff", d); end
      bus_write(4'h4, 32'hFFFF_FF5A, 4'h1);
      bus_read(4'h4, d);
      n_cmp++; if (d !== 32'h5A) begin n_bad++; $display("FAIL n8_be_lo got %h want 5a", d); end
      bus_write(4'hC, 32'h0, 4'hF);
      bus_read(4'hC, d);
      n_cmp++; if (d !== 32'h81) begin n_bad++; $display("FAIL n8_status got %h want 81", d); end
      bus_write(4'h8, 32'hFFFF_FFFF, 4'hF);
      bus_read(4'h8, d);
      n_cmp++; if (d !== 32'hFF) begin n_bad++; $display("FAIL n8_mode got %h want ff", d); end
      sel8 = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      logic [31:0] d;
      irqs_a = '0;
      irqs_b = '0;
      repeat (4) @(negedge clk);
      @(negedge clk);
      bus_req = 1'b1; bus_we = 1'b0; bus_addr = 4'h8; bus_be = 4'hF;
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      bus_req = 1'b0;
      n_cmp++; if (rvalid_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_rvalid got %b want 0", rvalid_a); end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++; if (rvalid_a !== 1'b0) begin n_bad++; $display("FAIL rst_post_rvalid%0d got %b want 0", c, rvalid_a); end
      end
      for (int a = 0; a < 3; a++) begin
         bus_read(4'(a * 4), d);
         n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_mid_reg%0d got %h want 0", a, d); end
      end
   endtask

   initial begin
      test_reset();
      test_level();
      test_edge_hold();
      test_set_wins();
      test_mode_switch();
      test_enable_drop();
      test_back_to_back();
      test_narrow();
      test_reset_mid_access();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
